// File: rtl/yuv2rgb_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : yuv2rgb_top
// Purpose  : Streams full-resolution Y/U/V planes from SRAM two pixels at a
//            time and converts each pixel to RGB565 with fixed-point BT.601
//            arithmetic. The packed results are written back to SRAM.
//            A single start/done handshake controls one frame.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-high
//            start      - begin one frame (sampled only when idle)
//            done       - one-cycle pulse at end of frame
//            raddr      - SRAM read address
//            rdata      - SRAM read data, valid the cycle after raddr
//            waddr      - SRAM write address
//            wdata      - SRAM write data (RGB565)
//            wr_enable  - SRAM write strobe, one word per high cycle
// Revision : 1.0 - initial release
// ============================================================================
module yuv2rgb_top #(
   parameter int unsigned W             = 320,
   parameter int unsigned H             = 240,
   parameter int unsigned DW            = 16,
   parameter int unsigned AW            = 18,
   parameter int unsigned Y_ADDR_BASE   = 0,
   parameter int unsigned U_ADDR_BASE   = 115200,
   parameter int unsigned V_ADDR_BASE   = 153600,
   parameter int unsigned RGB_ADDR_BASE = 38400
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rdata,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic          wr_enable
);

   localparam int unsigned P  = W * H / 2;
   localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;

   // BT.601 coefficients scaled by 2^16
   localparam logic signed [28:0] C_K_Y  = 29'sd76284;
   localparam logic signed [28:0] C_K_RV = 29'sd104595;
   localparam logic signed [28:0] C_K_GU = 29'sd25624;
   localparam logic signed [28:0] C_K_GV = 29'sd53281;
   localparam logic signed [28:0] C_K_BU = 29'sd132251;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_RY   = 4'd1,
      S_RU   = 4'd2,
      S_RV   = 4'd3,
      S_CAP  = 4'd4,
      S_CALC = 4'd5,
      S_W0   = 4'd6,
      S_W1   = 4'd7,
      S_DONE = 4'd8
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] p_q, p_d;
   logic [DW-1:0] y_q, y_d;
   logic [DW-1:0] u_q, u_d;
   logic [DW-1:0] v_q, v_d;
   logic [15:0]   pix0_q, pix0_d;
   logic [15:0]   pix1_q, pix1_d;
   logic          w_last_pair;

   // Saturate a signed intermediate to the 0..255 sample range.
   function automatic logic [7:0] clip8(input logic signed [28:0] x);
      logic [7:0] res;
      if (x < 0)
         res = 8'd0;
      else if (x > 29'sd255)
         res = 8'hFF;
      else
         res = x[7:0];
      return res;
   endfunction

   // One pixel: offsets are carried in the 29-bit accumulator width directly;
   // the values are identical to their 9-bit signed forms.
   function automatic logic [15:0] rgb565(input logic [7:0] ys8,
                                          input logic [7:0] us8,
                                          input logic [7:0] vs8);
      logic signed [28:0] y, u, v, r, g, b;
      logic [7:0]         r8, g8, b8;
      y  = $signed({21'd0, ys8}) - 29'sd16;
      u  = $signed({21'd0, us8}) - 29'sd128;
      v  = $signed({21'd0, vs8}) - 29'sd128;
      // Arithmetic shift floors toward -inf; no rounding term by design.
      r  = (C_K_Y * y + C_K_RV * v) >>> 16;
      g  = (C_K_Y * y - C_K_GU * u - C_K_GV * v) >>> 16;
      b  = (C_K_Y * y + C_K_BU * u) >>> 16;
      r8 = clip8(r);
      g8 = clip8(g);
      b8 = clip8(b);
      return {r8[7:3], g8[7:2], b8[7:3]};
   endfunction

   assign w_last_pair = (p_q == PW'(P - 1));

   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      y_d       = y_q;
      u_d       = u_q;
      v_d       = v_q;
      pix0_d    = pix0_q;
      pix1_d    = pix1_q;
      raddr     = '0;
      waddr     = '0;
      wdata     = '0;
      wr_enable = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               p_d     = '0;
               state_d = S_RY;
            end
         end
         S_RY: begin
            raddr   = AW'(Y_ADDR_BASE) + AW'(p_q);
            state_d = S_RU;
         end
         S_RU: begin
            // rdata now carries the Y word requested in RY
            raddr   = AW'(U_ADDR_BASE) + AW'(p_q);
            y_d     = rdata;
            state_d = S_RV;
         end
         S_RV: begin
            raddr   = AW'(V_ADDR_BASE) + AW'(p_q);
            u_d     = rdata;
            state_d = S_CAP;
         end
         S_CAP: begin
            v_d     = rdata;
            state_d = S_CALC;
         end
         S_CALC: begin
            // high byte = even (left) pixel, low byte = odd pixel
            pix0_d  = rgb565(y_q[DW-1:DW/2], u_q[DW-1:DW/2], v_q[DW-1:DW/2]);
            pix1_d  = rgb565(y_q[DW/2-1:0],  u_q[DW/2-1:0],  v_q[DW/2-1:0]);
            state_d = S_W0;
         end
         S_W0: begin
            wr_enable = 1'b1;
            waddr     = AW'(RGB_ADDR_BASE) + AW'({p_q, 1'b0});
            wdata     = pix0_q;
            state_d   = S_W1;
         end
         S_W1: begin
            wr_enable = 1'b1;
            waddr     = AW'(RGB_ADDR_BASE) + AW'({p_q, 1'b1});
            wdata     = pix1_q;
            if (w_last_pair) begin
               state_d = S_DONE;
            end else begin
               p_d     = p_q + 1'b1;
               state_d = S_RY;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         y_q     <= '0;
         u_q     <= '0;
         v_q     <= '0;
         pix0_q  <= '0;
         pix1_q  <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         y_q     <= y_d;
         u_q     <= u_d;
         v_q     <= v_d;
         pix0_q  <= pix0_d;
         pix1_q  <= pix1_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_yuv2rgb_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_yuv2rgb_top
// Purpose  : Self-checking bench for yuv2rgb_top on a 4x2 frame. An SRAM
//            model serves reads; every write is matched against a queue of
//            expected (address, data) pairs filled when a frame is loaded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yuv2rgb_top;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int DW    = 16;
   localparam int AW    = 18;
   localparam int YB    = 0;
   localparam int UB    = 115200;
   localparam int VB    = 153600;
   localparam int RB    = 38400;
   localparam int P     = W * H / 2;
   localparam int FRAME = 7 * P;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          done;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          wr_enable;

   always #5 clk = ~clk;

   yuv2rgb_top #(
      .W(W), .H(H), .DW(DW), .AW(AW),
      .Y_ADDR_BASE(YB), .U_ADDR_BASE(UB), .V_ADDR_BASE(VB), .RGB_ADDR_BASE(RB)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata),
      .wr_enable(wr_enable)
   );

   // SRAM read port: one-cycle latency
   logic [15:0] mem [int];
   always @(posedge clk)
      rdata <= mem.exists(int'(raddr)) ? mem[int'(raddr)] : 16'h0000;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_cmp    = 0;
   int  n_fail   = 0;
   int  n_writes = 0;
   int  n_done   = 0;
   bit  mon_en   = 1'b0;

   // Write scoreboard, done counter and read-address bound check
   always @(negedge clk) begin
      if (mon_en) begin
         if (done === 1'b1) n_done++;
         if (wr_enable === 1'b1) begin
            n_writes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: waddr=%0d wdata=%h, no write expected", waddr, wdata);
            end else begin
               mon_e = exp_q.pop_front();
               if (waddr !== mon_e.a || wdata !== mon_e.d) begin
                  n_fail++;
                  $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                           waddr, wdata, mon_e.a, mon_e.d);
               end
            end
         end
         n_cmp++;
         if (!((int'(raddr) >= YB && int'(raddr) < YB + P) ||
               (int'(raddr) >= UB && int'(raddr) < UB + P) ||
               (int'(raddr) >= VB && int'(raddr) < VB + P))) begin
            n_fail++;
            $display("FAIL raddr_range: raddr=%0d lies outside every plane", raddr);
         end
      end
   end

   function automatic int clip(input int x);
      return (x < 0) ? 0 : ((x > 255) ? 255 : x);
   endfunction

   function automatic logic [15:0] model(input logic [7:0] yy, input logic [7:0] uu,
                                         input logic [7:0] vv);
      int y, u, v, r, g, b;
      y = int'(yy) - 16;
      u = int'(uu) - 128;
      v = int'(vv) - 128;
      r = clip((76284 * y + 104595 * v) >>> 16);
      g = clip((76284 * y - 25624 * u - 53281 * v) >>> 16);
      b = clip((76284 * y + 132251 * u) >>> 16);
      return {r[7:3], g[7:2], b[7:3]};
   endfunction

   task automatic load_pair(input int p, input logic [15:0] yw, input logic [15:0] uw,
                            input logic [15:0] vw);
      mem[YB + p] = yw;
      mem[UB + p] = uw;
      mem[VB + p] = vw;
   endtask

   task automatic push_pair(input int p, input logic [15:0] d0, input logic [15:0] d1);
      wr_t t;
      t.a = AW'(RB + 2 * p);     t.d = d0; exp_q.push_back(t);
      t.a = AW'(RB + 2 * p + 1); t.d = d1; exp_q.push_back(t);
   endtask

   task automatic push_model(input int p);
      logic [15:0] yw, uw, vw;
      yw = mem[YB + p]; uw = mem[UB + p]; vw = mem[VB + p];
      push_pair(p, model(yw[15:8], uw[15:8], vw[15:8]), model(yw[7:0], uw[7:0], vw[7:0]));
   endtask

   task automatic load_random(input int p);
      load_pair(p, 16'($urandom()), 16'($urandom()), 16'($urandom()));
   endtask

   // Stimulus only: launch one frame, optionally pulse start at given edge
   // counts, and return the edge count (from the start edge) of done.
   task automatic run_frame(input int inj1, input int inj2, output int edges, output bit got);
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      edges = 0;
      got   = 1'b0;
      while (!got && edges < FRAME + 20) begin
         start = (edges == inj1 || edges == inj2);
         @(posedge clk); edges++; @(negedge clk);
         if (done === 1'b1) got = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b1;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if ({done, wr_enable, raddr, waddr, wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b wr_enable=%b raddr=%0d waddr=%0d wdata=%h, required all 0",
                     done, wr_enable, raddr, waddr, wdata);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (wr_enable !== 1'b0 || done !== 1'b0 || raddr !== '0) begin
         n_fail++;
         $display("FAIL idle_after_reset: wr_enable=%b done=%b raddr=%0d, required 0",
                  wr_enable, done, raddr);
      end
   endtask

   task automatic test_small_frame;
      int edges, w0, d0;
      bit got;
      mem.delete();
      for (int p = 0; p < P; p++) begin
         load_pair(p, 16'h1010, 16'h8080, 16'h8080);
         push_pair(p, 16'h0000, 16'h0000);
      end
      w0 = n_writes; d0 = n_done;
      run_frame(-1, -1, edges, got);
      n_cmp++;
      if (!got || edges != FRAME) begin
         n_fail++;
         $display("FAIL small_done_latency: done after %0d edges (seen=%0d), required %0d", edges, got, FRAME);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL small_done_pulse: done=%b one cycle later, required 0", done);
      end
      n_cmp++;
      if (n_writes - w0 != 2 * P || exp_q.size() != 0 || n_done - d0 != 1) begin
         n_fail++;
         $display("FAIL small_counts: writes=%0d left=%0d dones=%0d, required %0d/0/1",
                  n_writes - w0, exp_q.size(), n_done - d0, 2 * P);
      end
      exp_q.delete();
   endtask

   task automatic test_colour_vectors;
      int edges, w0;
      bit got;
      mem.delete();
      load_pair(0, 16'hEB51, 16'h805A, 16'h80F0);
      push_pair(0, 16'hFFFF, 16'hF800);
      for (int p = 1; p < P; p++) begin
         load_random(p);
         push_model(p);
      end
      w0 = n_writes;
      run_frame(-1, -1, edges, got);
      n_cmp++;
      if (!got || edges != FRAME || n_writes - w0 != 2 * P || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL colour_frame: done_edge=%0d seen=%0d writes=%0d left=%0d, required %0d/1/%0d/0",
                  edges, got, n_writes - w0, exp_q.size(), FRAME, 2 * P);
      end
      exp_q.delete();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_clipping;
      int edges, w0;
      bit got;
      mem.delete();
      // pixel1: R underflows to 0, G = 54, B overflows to 255
      load_pair(0, 16'hFF10, 16'h80FF, 16'h8000);
      push_pair(0, 16'hFFFF, 16'h01BF);
      load_pair(1, 16'h00FF, 16'h00FF, 16'hFF00);
      push_model(1);
      for (int p = 2; p < P; p++) begin
         load_random(p);
         push_model(p);
      end
      w0 = n_writes;
      run_frame(-1, -1, edges, got);
      n_cmp++;
      if (!got || edges != FRAME || n_writes - w0 != 2 * P || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL clip_frame: done_edge=%0d seen=%0d writes=%0d left=%0d, required %0d/1/%0d/0",
                  edges, got, n_writes - w0, exp_q.size(), FRAME, 2 * P);
      end
      exp_q.delete();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_start_ignored;
      int edges, w0, d0;
      bit got;
      mem.delete();
      for (int p = 0; p < P; p++) begin
         load_random(p);
         push_model(p);
      end
      w0 = n_writes; d0 = n_done;
      // edge 8 leaves RU of pair 1 active, edge 20 leaves W1 of pair 2 active
      run_frame(8, 20, edges, got);
      n_cmp++;
      if (!got || edges != FRAME) begin
         n_fail++;
         $display("FAIL start_ignored_latency: done after %0d edges (seen=%0d), required %0d", edges, got, FRAME);
      end
      repeat (10) begin @(posedge clk); @(negedge clk); end
      n_cmp++;
      if (n_writes - w0 != 2 * P || n_done - d0 != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL start_ignored_counts: writes=%0d dones=%0d left=%0d, required %0d/1/0",
                  n_writes - w0, n_done - d0, exp_q.size(), 2 * P);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midframe;
      int n, w0, d0;
      bit got;
      mem.delete();
      for (int p = 0; p < P; p++) load_random(p);
      push_model(0);
      push_model(1);
      w0 = n_writes; d0 = n_done;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 7 * 2 + 4) begin @(posedge clk); n++; @(negedge clk); end
      reset = 1'b1;                       // sampled while pair 2 is in CALC
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({done, wr_enable, raddr, waddr, wdata} !== '0) begin
         n_fail++;
         $display("FAIL midframe_reset_outputs: done=%b wr_enable=%b raddr=%0d waddr=%0d wdata=%h, required all 0",
                  done, wr_enable, raddr, waddr, wdata);
      end
      repeat (10) begin @(posedge clk); @(negedge clk); end
      n_cmp++;
      if (n_writes - w0 != 4 || n_done != d0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL midframe_reset_writes: writes=%0d dones=%0d left=%0d, required 4/0/0",
                  n_writes - w0, n_done - d0, exp_q.size());
      end
      exp_q.delete();
      // restart must begin again at pair 0
      for (int p = 0; p < P; p++) push_model(p);
      w0 = n_writes;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (raddr !== AW'(YB)) begin
         n_fail++;
         $display("FAIL restart_raddr_y: raddr=%0d, required %0d", raddr, YB);
      end
      @(posedge clk); @(negedge clk);
      n = 1;
      n_cmp++;
      if (raddr !== AW'(UB)) begin
         n_fail++;
         $display("FAIL restart_raddr_u: raddr=%0d, required %0d", raddr, UB);
      end
      got = 1'b0;
      while (!got && n < FRAME + 20) begin
         @(posedge clk); n++; @(negedge clk);
         if (done === 1'b1) got = 1'b1;
      end
      n_cmp++;
      if (!got || n != FRAME || n_writes - w0 != 2 * P || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL restart_frame: done_edge=%0d seen=%0d writes=%0d left=%0d, required %0d/1/%0d/0",
                  n, got, n_writes - w0, exp_q.size(), FRAME, 2 * P);
      end
      exp_q.delete();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n, first, second, w0, d0;
      mem.delete();
      for (int p = 0; p < P; p++) load_random(p);
      for (int f = 0; f < 2; f++)
         for (int p = 0; p < P; p++) push_model(p);
      w0 = n_writes; d0 = n_done;
      start  = 1'b1;
      @(posedge clk); @(negedge clk);
      n      = 0;
      first  = -1;
      second = -1;
      while (second < 0 && n < 2 * FRAME + 20) begin
         @(posedge clk); n++; @(negedge clk);
         if (n == FRAME + 2) start = 1'b0;
         if (done === 1'b1) begin
            if (first < 0) first = n;
            else second = n;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (first != FRAME) begin
         n_fail++;
         $display("FAIL b2b_first_done: edge=%0d, required %0d", first, FRAME);
      end
      n_cmp++;
      if (second != 2 * FRAME + 2) begin
         n_fail++;
         $display("FAIL b2b_second_done: edge=%0d, required %0d", second, 2 * FRAME + 2);
      end
      repeat (5) begin @(posedge clk); @(negedge clk); end
      n_cmp++;
      if (n_writes - w0 != 4 * P || n_done - d0 != 2 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_counts: writes=%0d dones=%0d left=%0d, required %0d/2/0",
                  n_writes - w0, n_done - d0, exp_q.size(), 4 * P);
      end
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      test_reset();
      test_small_frame();
      test_colour_vectors();
      test_clipping();
      test_start_ignored();
      test_reset_midframe();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
